// File: rtl/spinner_pkg.sv
// Shared quadrature types and state-stepping helpers for the spinner emulator.
package spinner_pkg;

    typedef logic [1:0] quad_t;

    localparam quad_t Q00 = 2'b00;
    localparam quad_t Q01 = 2'b01;
    localparam quad_t Q11 = 2'b11;
    localparam quad_t Q10 = 2'b10;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic quad_t quad_fwd(input quad_t q);
        quad_t r;
        case (q)
            Q00:     r = Q01;
            Q01:     r = Q11;
            Q11:     r = Q10;
            default: r = Q00;
        endcase
        return r;
    endfunction

    function automatic quad_t quad_rev(input quad_t q);
        quad_t r;
        case (q)
            Q00:     r = Q10;
            Q10:     r = Q11;
            Q11:     r = Q01;
            default: r = Q00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spinner_emu_quad_decoder.sv
// Physical encoder front end: 2-FF synchronizer, optional stability filter
// (SPINNER_DEBOUNCE_EN) and A-edge decode that halves a 600-pulse encoder to 300.
module quad_decoder
    import spinner_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] enc_in,
    output quad_t      raw_q,
    output logic       change
);

    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] filt;
    logic [1:0] filt_prev;

    // Idle user-port lines float high, so reset to 11 to avoid a spurious change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= enc_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef SPINNER_DEBOUNCE_EN
    logic [1:0] cand;
    logic [1:0] stable_cnt;
    logic [1:0] filt_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            cand       <= 2'b11;
            stable_cnt <= 2'd0;
            filt_r     <= 2'b11;
        end else if (sync_p1 != cand) begin
            cand       <= sync_p1;
            stable_cnt <= 2'd0;
        end else if (stable_cnt != 2'd3) begin
            stable_cnt <= stable_cnt + 2'd1;
        end else begin
            filt_r <= cand;
        end
    end

    assign filt = filt_r;
`else
    assign filt = sync_p1;
`endif

    assign change = (filt != filt_prev);

    // Only A edges advance the state; A^B after the edge gives the direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_prev <= 2'b11;
            raw_q     <= Q11;
        end else begin
            filt_prev <= filt;
            if (filt[0] != filt_prev[0]) begin
                raw_q <= (filt[0] ^ filt[1]) ? quad_fwd(raw_q) : quad_rev(raw_q);
            end
        end
    end

endmodule

// File: rtl/spinner_emu.sv
// Arkanoid spinner emulator: merges mouse, USB spinner, D-pad, analog stick and a
// physical encoder into one AB quadrature output. Optional macro: SPINNER_DEBOUNCE_EN.
module spinner_emu
    import spinner_pkg::*;
#(
    parameter int TICK_DIV  = 1500,
    parameter int POLL_DIV  = 48000,
    parameter int DPAD_SLOW = 4,
    parameter int DPAD_FAST = 9,
    parameter int POS_W     = 12
) (
    input  logic       clk_12m,
    input  logic       reset,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [1:0] spin_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fast,
    input  logic [7:0] analog_x,
    input  logic [1:0] enc_in,
    output logic [1:0] spinner,
    output logic       use_io
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int POLL_W = $clog2(POLL_DIV + 1);

    localparam logic signed [POS_W-1:0] ONE        = POS_W'(1);
    localparam logic signed [POS_W-1:0] SPRES_BASE = POS_W'(2);
    localparam logic signed [POS_W-1:0] DPAD_S     = POS_W'(DPAD_SLOW);
    localparam logic signed [POS_W-1:0] DPAD_F     = POS_W'(DPAD_FAST);

    logic                    ce_6m;
    logic [TICK_W-1:0]       div_tick;
    logic [POLL_W-1:0]       poll_cnt;
    logic [POLL_W-1:0]       poll_n;
    logic signed [POS_W-1:0] position;
    logic signed [POS_W-1:0] position_n;
    quad_t                   emu_q;
    quad_t                   emu_q_n;
    logic                    strobe_q;
    logic                    emu_clr_io;
    logic                    poll_hit;
    logic [1:0]              spres_sh;
    logic signed [POS_W-1:0] spres;
    logic signed [POS_W-1:0] dx_ext;
    logic signed [POS_W-1:0] analog_step;
    logic signed [POS_W-1:0] dpad_mag;
    quad_t                   raw_q;
    logic                    enc_change;

    // Mouse deltas are refused once the top two bits disagree, so the sum never wraps.
    function automatic logic near_sat(input logic signed [POS_W-1:0] p);
        return p[POS_W-1] != p[POS_W-2];
    endfunction

    quad_decoder u_dec (
        .clk    (clk_12m),
        .reset  (reset),
        .enc_in (enc_in),
        .raw_q  (raw_q),
        .change (enc_change)
    );

    assign spres_sh    = spin_mode - {1'b0, ~btn_fast};
    assign spres       = SPRES_BASE <<< spres_sh;
    assign dx_ext      = {{(POS_W-9){mouse_dx[8]}}, mouse_dx};
    assign analog_step = (analog_x[7:4] != 4'd0) ? {{(POS_W-4){analog_x[7]}}, analog_x[7:4]} : ONE;
    assign dpad_mag    = btn_fast ? DPAD_F : DPAD_S;
    assign poll_hit    = (poll_cnt == POLL_W'(POLL_DIV - 1));

    // Later assignments win, mirroring the priority of the input sources.
    always_comb begin
        position_n = position;
        emu_q_n    = emu_q;
        poll_n     = '0;
        emu_clr_io = 1'b0;

        if (div_tick == '0 && position != '0) begin
            if (position[POS_W-1]) begin
                emu_q_n    = quad_fwd(emu_q);
                position_n = position + ONE;
            end else begin
                emu_q_n    = quad_rev(emu_q);
                position_n = position - ONE;
            end
        end

        if (mouse_strobe != strobe_q) begin
            emu_clr_io = 1'b1;
            if (!near_sat(position)) begin
                position_n = position + dx_ext;
            end
        end

        if (spin_mode != 2'd0 && (btn_left || btn_right)) begin
            position_n = btn_right ? spres : -spres;
            emu_clr_io = 1'b1;
        end else if (spin_mode == 2'd0 && analog_x != 8'd0) begin
            emu_clr_io = 1'b1;
            if (poll_hit) begin
                position_n = analog_step;
            end else begin
                poll_n = poll_cnt + POLL_W'(1);
            end
        end else if (spin_mode == 2'd0 && (btn_left || btn_right)) begin
            emu_clr_io = 1'b1;
            if (poll_hit) begin
                position_n = btn_right ? dpad_mag : -dpad_mag;
            end else begin
                poll_n = poll_cnt + POLL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_12m) begin
        if (reset) begin
            ce_6m    <= 1'b0;
            div_tick <= '0;
            poll_cnt <= '0;
            position <= '0;
            emu_q    <= Q11;
            strobe_q <= 1'b0;
        end else begin
            ce_6m <= ~ce_6m;
            if (ce_6m) begin
                div_tick <= (div_tick == TICK_W'(TICK_DIV - 1)) ? '0 : div_tick + TICK_W'(1);
                poll_cnt <= poll_n;
                position <= position_n;
                emu_q    <= emu_q_n;
                strobe_q <= mouse_strobe;
            end
        end
    end

    // Encoder activity claims the output; any emulated source hands it back.
    always_ff @(posedge clk_12m) begin
        if (reset) begin
            use_io  <= 1'b0;
            spinner <= Q11;
        end else begin
            if (enc_change) begin
                use_io <= 1'b1;
            end else if (ce_6m && emu_clr_io) begin
                use_io <= 1'b0;
            end
            spinner <= use_io ? raw_q : emu_q;
        end
    end

endmodule
